// File: rtl/mem_write_monitor.sv
// Memory-write bus monitor: captures output-window writes into a FWFT FIFO,
// detects the program halt write and ends runs that never halt with a watchdog.
module mem_write_monitor #(
    parameter int unsigned    N              = 16,
    parameter int unsigned    A              = 16,
    parameter int unsigned    DEPTH          = 8,
    parameter logic [A-1:0]   OUT_BASE       = A'(16'hFF00),
    parameter logic [A-1:0]   OUT_MASK       = A'(16'hFF00),
    parameter logic [A-1:0]   HALT_ADDR      = A'(16'hFFFF),
    parameter bit             CAPTURE_ALL    = 1'b0,
    parameter int unsigned    TIMEOUT_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mw,
    input  logic [A-1:0]                 addr,
    input  logic [N-1:0]                 wd,
    input  logic                         pop,
    output logic [N-1:0]                 rd_data,
    output logic [A-1:0]                 rd_addr,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         halted,
    output logic                         timed_out,
    output logic [N-1:0]                 halt_code,
    output logic [15:0]                  write_cnt
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned TW = 32;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_HALTED  = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] cyc_q;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_d;
    logic [A-1:0]  mem_addr [DEPTH];
    logic [N-1:0]  mem_data [DEPTH];

    logic in_run, halt_wr, tmo_hit, enter_run, capture, do_pop, do_push;

    assign in_run    = (state_q == S_RUN);
    assign halt_wr   = mw && (addr == HALT_ADDR);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (cyc_q == TW'(TIMEOUT_CYCLES - 1));
    assign enter_run = start && !in_run;
    assign capture   = in_run && mw && !halt_wr &&
                       (((addr & OUT_MASK) == OUT_BASE) || CAPTURE_ALL);
    assign do_pop    = pop && !empty;
    assign do_push   = capture && (!full || do_pop);

    assign rd_data = mem_data[rd_ptr];
    assign rd_addr = mem_addr[rd_ptr];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state; halt takes priority over the watchdog on the same edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (halt_wr)      state_d = S_HALTED;
                else if (tmo_hit) state_d = S_TIMEOUT;
            end
            default: begin
                if (start) state_d = S_RUN;
            end
        endcase
    end

    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // FIFO storage carries no reset; contents are only observable when non-empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= addr;
            mem_data[wr_ptr] <= wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q     <= '0;
            write_cnt <= '0;
            overflow  <= 1'b0;
            halt_code <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            halted    <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            if (enter_run)   cyc_q <= '0;
            else if (in_run) cyc_q <= cyc_q + TW'(1);

            if (enter_run)
                write_cnt <= '0;
            else if (in_run && mw && (write_cnt != 16'hFFFF))
                write_cnt <= write_cnt + 16'd1;

            if (enter_run)                        overflow <= 1'b0;
            else if (capture && full && !do_pop)  overflow <= 1'b1;

            if (in_run && halt_wr) halt_code <= wd;

            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count     <= count_d;
            empty     <= (count_d == '0);
            full      <= (count_d == CW'(DEPTH));
            halted    <= (state_d == S_HALTED);
            timed_out <= (state_d == S_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_mem_write_monitor.sv
// Bench for mem_write_monitor: two configurations share one stimulus stream and
// each is compared every cycle against a queue-based reference model.
module tb_mem_write_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mw = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wd = '0;
    logic        pop = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Instance 0: defaults. Instance 1: short watchdog, capture every write.
    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned TMO  = (g == 0) ? 1000 : 20;
        localparam bit          CALL = (g == 1);

        logic [15:0] rd_data, rd_addr, halt_code, write_cnt;
        logic [3:0]  count;
        logic        empty, full, overflow, halted, timed_out;

        mem_write_monitor #(
            .N(16), .A(16), .DEPTH(8),
            .OUT_BASE(16'hFF00), .OUT_MASK(16'hFF00), .HALT_ADDR(16'hFFFF),
            .CAPTURE_ALL(CALL), .TIMEOUT_CYCLES(TMO)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start), .mw(mw), .addr(addr), .wd(wd),
            .pop(pop), .rd_data(rd_data), .rd_addr(rd_addr), .empty(empty),
            .full(full), .count(count), .overflow(overflow), .halted(halted),
            .timed_out(timed_out), .halt_code(halt_code), .write_cnt(write_cnt)
        );

        // Reference model: 0 idle, 1 run, 2 halted, 3 timeout
        logic [31:0] q[$];
        int          m_st = 0;
        int unsigned m_cyc = 0;
        int unsigned m_wc = 0;
        bit          m_ovf = 1'b0;
        logic [15:0] m_hc = '0;
        bit          is_halt, cap;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                q.delete();
                m_st = 0; m_cyc = 0; m_wc = 0; m_ovf = 1'b0; m_hc = '0;
            end else begin
                is_halt = mw && (addr == 16'hFFFF);
                cap = (m_st == 1) && mw && !is_halt && (((addr & 16'hFF00) == 16'hFF00) || CALL);
                if (pop && q.size() > 0) void'(q.pop_front());
                if (cap) begin
                    if (q.size() < 8) q.push_back({addr, wd});
                    else m_ovf = 1'b1;
                end
                if (m_st == 1) begin
                    if (mw && m_wc < 65535) m_wc++;
                    if (is_halt) begin
                        m_hc = wd;
                        m_st = 2;
                    end else if (TMO != 0 && m_cyc == TMO - 1) begin
                        m_st = 3;
                    end
                    m_cyc++;
                end else if (start) begin
                    m_st = 1; m_cyc = 0; m_wc = 0; m_ovf = 1'b0;
                end
            end
        end

        always @(posedge clk or posedge rst) begin
            #1;
            chk($sformatf("i%0d.count", g), 32'(count), 32'(q.size()));
            chk($sformatf("i%0d.empty", g), 32'(empty), 32'(q.size() == 0));
            chk($sformatf("i%0d.full", g), 32'(full), 32'(q.size() == 8));
            chk($sformatf("i%0d.overflow", g), 32'(overflow), 32'(m_ovf));
            chk($sformatf("i%0d.halted", g), 32'(halted), 32'(m_st == 2));
            chk($sformatf("i%0d.timed_out", g), 32'(timed_out), 32'(m_st == 3));
            chk($sformatf("i%0d.halt_code", g), 32'(halt_code), 32'(m_hc));
            chk($sformatf("i%0d.write_cnt", g), 32'(write_cnt), m_wc);
            if (q.size() != 0) begin
                chk($sformatf("i%0d.rd_addr", g), 32'(rd_addr), 32'(q[0][31:16]));
                chk($sformatf("i%0d.rd_data", g), 32'(rd_data), 32'(q[0][15:0]));
            end
        end
    end

    task automatic drive(input logic s, input logic m, input logic [15:0] a,
                         input logic [15:0] d, input logic p);
        @(negedge clk);
        start = s; mw = m; addr = a; wd = d; pop = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic halt_and_drain();
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        idle(1);
    endtask

    initial begin
        #1 rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // First output write then halt
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b0, 1'b1, 16'hFF00, 16'h0037, 1'b0);
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        idle(1);
        chk("t1.count", 32'(g_cfg[0].count), 32'd1);
        chk("t1.rd_addr", 32'(g_cfg[0].rd_addr), 32'hFF00);
        chk("t1.rd_data", 32'(g_cfg[0].rd_data), 32'h0037);
        chk("t1.halted", 32'(g_cfg[0].halted), 32'd1);
        chk("t1.halt_code", 32'(g_cfg[0].halt_code), 32'h0001);
        halt_and_drain();

        // Overfill the FIFO, then drain in order
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 16'hFF00 + 16'(i), 16'(i + 1), 1'b0);
        idle(1);
        chk("t2.full", 32'(g_cfg[0].full), 32'd1);
        chk("t2.overflow", 32'(g_cfg[0].overflow), 32'd1);
        chk("t2.count", 32'(g_cfg[0].count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2.order", 32'(g_cfg[0].rd_data), 32'(i + 1));
            drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
            idle(1);
        end
        chk("t2.empty", 32'(g_cfg[0].empty), 32'd1);
        halt_and_drain();

        // Watchdog fires 20 cycles after start on instance 1
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        idle(20);
        chk("t3.not_yet", 32'(g_cfg[1].timed_out), 32'd0);
        idle(1);
        chk("t3.timed_out", 32'(g_cfg[1].timed_out), 32'd1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'hFF10, 16'h1234, 1'b0);
        idle(1);
        chk("t3.write_cnt", 32'(g_cfg[1].write_cnt), 32'd0);
        chk("t3.count", 32'(g_cfg[1].count), 32'd0);
        halt_and_drain();

        // Out-of-window write: dropped normally, captured in capture-all mode
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b0, 1'b1, 16'h0100, 16'h0005, 1'b0);
        idle(1);
        chk("t4.wcnt", 32'(g_cfg[0].write_cnt), 32'd1);
        chk("t4.nocap", 32'(g_cfg[0].empty), 32'd1);
        chk("t4.cap_cnt", 32'(g_cfg[1].count), 32'd1);
        chk("t4.cap_data", 32'(g_cfg[1].rd_data), 32'h0005);
        halt_and_drain();

        // Capture and pop together while full
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 16'hFF20, 16'h0100 + 16'(i), 1'b0);
        idle(1);
        chk("t5.full", 32'(g_cfg[0].full), 32'd1);
        drive(1'b0, 1'b1, 16'hFF21, 16'hAAAA, 1'b1);
        idle(1);
        chk("t5.count", 32'(g_cfg[0].count), 32'd8);
        chk("t5.overflow", 32'(g_cfg[0].overflow), 32'd0);
        chk("t5.head", 32'(g_cfg[0].rd_data), 32'h0101);
        halt_and_drain();

        // Reset in the middle of a run
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'hFF30, 16'(i), 1'b0);
        idle(1);
        chk("t6.count3", 32'(g_cfg[0].count), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6.count", 32'(g_cfg[0].count), 32'd0);
        chk("t6.empty", 32'(g_cfg[0].empty), 32'd1);
        chk("t6.wcnt", 32'(g_cfg[0].write_cnt), 32'd0);
        chk("t6.halted", 32'(g_cfg[0].halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0042, 1'b0);
        idle(1);
        chk("t6.rehalt", 32'(g_cfg[0].halted), 32'd1);
        chk("t6.code", 32'(g_cfg[0].halt_code), 32'h0042);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            logic [15:0] a;
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 16'hFFFF;
            else if (r <= 5) a = 16'hFF00 | 16'($urandom_range(0, 255));
            else if (r == 6) a = 16'h0100;
            else             a = 16'($urandom);
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), a,
                  16'($urandom), ($urandom_range(0, 9) < 3));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
